frequency_divisor_generator: RTL and testbench
==============================================

Name: frequency_divisor_generator

Overview:
- User-adjustable clock-divisor register driven by three push-button level inputs.
- key_0 steps the divisor down (higher output frequency), key_1 steps it up (lower frequency), and key_2 restores the default.
- The value saturates within [min_divisor, max_divisor].
- Feeds a downstream clock/tone divider that consumes frequency_divisor directly.

Parameters:
- max_divisor, 32'd2272: upper saturation limit, inclusive.
- min_divisor, 32'd568: lower saturation limit, inclusive; must be <= max_divisor.
- default_divisor, 32'd1136: value loaded on reset and on key_2. Clamped into [min_divisor, max_divisor] if outside.
- step_size, 32'd1: amount added or subtracted per step.
- repeat_period, 32'd1: clock cycles between successive auto-repeat steps while a key is held; must be >= 1.

Ports:
- clk, input, 1: single system clock; all logic on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- key_0, input, 1: active-high "decrease divisor" request, asynchronous to clk.
- key_1, input, 1: active-high "increase divisor" request, asynchronous to clk.
- key_2, input, 1: active-high "restore default" request, asynchronous to clk.
- frequency_divisor, output, 32: current divisor, registered.

Behaviour:
- Reset:
  - Synchronous, active-low: on any rising clk edge with reset_n=0, frequency_divisor <= clamp(default_divisor).
  - Synchronizers and the repeat counter clear to 0.
  - Reset overrides all keys, including mid-hold.
- Input sync:
  - Each key passes through a 2-flop synchronizer.
  - A key that goes high before edge k is seen as synchronized-high after edge k+1.
  - The first divisor update occurs at edge k+2.
- Command decode, on synchronized values, highest priority first:
  - key_2=1: divisor <= clamp(default_divisor); repeat counter <= 0; key_0/key_1 ignored.
  - key_0=1 and key_1=1: no change; counter <= 0.
  - key_0=1 only: decrement request.
  - key_1=1 only: increment request.
  - No key: no change; counter <= 0.
- Step timing:
  - A step is applied on the first cycle a request is active (counter==0).
  - The counter then counts 1..repeat_period-1, and the next step occurs when it wraps to 0.
  - With repeat_period=1, a held key steps once every clock.
  - Switching directly from key_0 to key_1 restarts the counter, and the new direction steps immediately.
- Arithmetic, 32-bit unsigned with no wrap:
  - Decrement: if divisor <= min_divisor + step_size then divisor <= min_divisor, else divisor - step_size.
  - Increment: if divisor + step_size >= max_divisor (computed in 33 bits) then divisor <= max_divisor, else divisor + step_size.
  - Held at a limit, the value stays at the limit. The counter keeps running; no side effects.
- frequency_divisor is always within [min_divisor, max_divisor] after the first reset.
- Before the first reset its value is undefined; benches must apply reset.
- The output changes only on rising clk edges, never combinationally from the keys.

Test Plan:
- Reset: max=1140, min=1130, default=1136; hold reset_n=0 for 2 cycles, all keys 0 -> frequency_divisor=1136, stable with no keys.
- Decrement and saturate: release reset, hold key_0=1 for 10 cycles -> first change to 1135 two edges after key_0 rises, then 1134, 1133, ... one per cycle, saturating at 1130 and holding 1130.
- Increment and saturate: from 1130, hold key_1=1 for 20 cycles -> steps 1131..1140 one per cycle, then stays 1140 (no wrap to 0 or above max).
- Default/priority: from 1140, assert key_2 with key_0=1 -> 1136 two edges later and stays 1136 while key_2 is held.
- Conflict and repeat: key_0 and key_1 both held -> value unchanged; with repeat_period=4 and key_1 held from 1130 -> 1131, then +1 every 4 cycles.
- Reset mid-operation: hold key_1 from 1130, pull reset_n=0 for one edge after reaching 1134 -> 1136 at that edge; increments resume from 1136 after release (key still held).

Source files
------------

// File: rtl/frequency_divisor_generator.sv
// Push-button adjustable clock divisor: key_0 steps down, key_1 steps up, key_2 restores default.
// Keys are synchronized, held keys auto-repeat every repeat_period cycles, result saturates in range.
module frequency_divisor_generator #(
    parameter logic [31:0] max_divisor     = 32'd2272,
    parameter logic [31:0] min_divisor     = 32'd568,
    parameter logic [31:0] default_divisor = 32'd1136,
    parameter logic [31:0] step_size       = 32'd1,
    parameter logic [31:0] repeat_period   = 32'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_0,
    input  logic        key_1,
    input  logic        key_2,
    output logic [31:0] frequency_divisor
);

    localparam logic [31:0] DEFAULT_CLAMPED =
        (default_divisor < min_divisor) ? min_divisor :
        (default_divisor > max_divisor) ? max_divisor : default_divisor;
    localparam logic [31:0] LAST_COUNT = repeat_period - 32'd1;

    logic [2:0]  r_key_meta;
    logic [2:0]  r_key_sync;
    logic [31:0] r_divisor;
    logic [31:0] r_rpt_cnt;
    logic        r_dir_inc;

    logic        w_dec_req;
    logic        w_inc_req;
    logic        w_req;
    logic        w_step;
    logic [32:0] w_dec_floor;
    logic [32:0] w_inc_sum;
    logic [31:0] w_dec_value;
    logic [31:0] w_inc_value;
    logic [31:0] w_next_cnt;
    logic [31:0] w_step_cnt;

    always_comb begin
        w_dec_req = r_key_sync[0] & ~r_key_sync[1] & ~r_key_sync[2];
        w_inc_req = r_key_sync[1] & ~r_key_sync[0] & ~r_key_sync[2];
        w_req     = w_dec_req | w_inc_req;
        // A change of direction mid-count restarts the cadence and steps at once.
        w_step    = w_req & ((r_rpt_cnt == 32'd0) | (w_inc_req != r_dir_inc));

        w_dec_floor = {1'b0, min_divisor} + {1'b0, step_size};
        w_inc_sum   = {1'b0, r_divisor} + {1'b0, step_size};

        if ({1'b0, r_divisor} <= w_dec_floor) begin
            w_dec_value = min_divisor;
        end else begin
            w_dec_value = r_divisor - step_size;
        end

        if (w_inc_sum >= {1'b0, max_divisor}) begin
            w_inc_value = max_divisor;
        end else begin
            w_inc_value = w_inc_sum[31:0];
        end

        w_step_cnt = (LAST_COUNT == 32'd0) ? 32'd0 : 32'd1;
        w_next_cnt = (r_rpt_cnt >= LAST_COUNT) ? 32'd0 : r_rpt_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_key_meta <= 3'b000;
            r_key_sync <= 3'b000;
            r_divisor  <= DEFAULT_CLAMPED;
            r_rpt_cnt  <= 32'd0;
            r_dir_inc  <= 1'b0;
        end else begin
            r_key_meta <= {key_2, key_1, key_0};
            r_key_sync <= r_key_meta;

            if (r_key_sync[2]) begin
                r_divisor <= DEFAULT_CLAMPED;
                r_rpt_cnt <= 32'd0;
            end else if (w_req) begin
                if (w_step) begin
                    r_divisor <= w_inc_req ? w_inc_value : w_dec_value;
                    r_rpt_cnt <= w_step_cnt;
                end else begin
                    r_rpt_cnt <= w_next_cnt;
                end
                r_dir_inc <= w_inc_req;
            end else begin
                r_rpt_cnt <= 32'd0;
            end
        end
    end

    assign frequency_divisor = r_divisor;

endmodule

// File: tb/tb_frequency_divisor_generator.sv
// Directed table-driven bench for frequency_divisor_generator with a narrow 1130..1140 range.
// Instance A repeats every clock, instance B every 4 clocks.
module tb_frequency_divisor_generator;

    typedef struct packed {
        logic        rst_n;
        logic        k0;
        logic        k1;
        logic        k2;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        a_k0, a_k1, a_k2;
    logic        b_k0, b_k1, b_k2;
    logic [31:0] a_div;
    logic [31:0] b_div;

    int n_cmp;
    int n_bad;
    vec_t vecs[$];

    frequency_divisor_generator #(
        .max_divisor(32'd1140), .min_divisor(32'd1130), .default_divisor(32'd1136),
        .step_size(32'd1), .repeat_period(32'd1)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .key_0(a_k0), .key_1(a_k1), .key_2(a_k2),
        .frequency_divisor(a_div)
    );

    frequency_divisor_generator #(
        .max_divisor(32'd1140), .min_divisor(32'd1130), .default_divisor(32'd1136),
        .step_size(32'd1), .repeat_period(32'd4)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .key_0(b_k0), .key_1(b_k1), .key_2(b_k2),
        .frequency_divisor(b_div)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add_vec(input logic r, input logic k0, input logic k1,
                           input logic k2, input int e);
        vec_t v;
        v.rst_n = r;
        v.k0    = k0;
        v.k1    = k1;
        v.k2    = k2;
        v.exp   = e[31:0];
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    initial begin
        int b_exp[12];

        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        a_k0 = 1'b0; a_k1 = 1'b0; a_k2 = 1'b0;
        b_k0 = 1'b0; b_k1 = 1'b0; b_k2 = 1'b0;

        // Reset, then stable with no keys.
        for (int i = 0; i < 2; i++) add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1136);
        for (int i = 0; i < 2; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1136);
        // Decrement: two-edge latency, then one step per clock down to the floor.
        for (int i = 0; i < 10; i++)
            add_vec(1'b1, 1'b1, 1'b0, 1'b0, (i < 2) ? 1136 : ((1137 - i < 1130) ? 1130 : 1137 - i));
        for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1130);
        // Increment up to the ceiling without wrapping.
        for (int i = 0; i < 20; i++)
            add_vec(1'b1, 1'b0, 1'b1, 1'b0, (i < 2) ? 1130 : ((1129 + i > 1140) ? 1140 : 1129 + i));
        for (int i = 0; i < 2; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1140);
        // Restore default wins over a simultaneous decrement.
        for (int i = 0; i < 6; i++) add_vec(1'b1, 1'b1, 1'b0, 1'b1, (i < 2) ? 1140 : 1136);
        for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1136);
        // Both direction keys held: no change.
        for (int i = 0; i < 5; i++) add_vec(1'b1, 1'b1, 1'b1, 1'b0, 1136);
        for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1136);
        // Back to the floor, then switch straight to increment.
        for (int i = 0; i < 9; i++)
            add_vec(1'b1, 1'b1, 1'b0, 1'b0, (i < 2) ? 1136 : ((1137 - i < 1130) ? 1130 : 1137 - i));
        for (int i = 0; i < 6; i++)
            add_vec(1'b1, 1'b0, 1'b1, 1'b0, (i < 2) ? 1130 : 1129 + i);
        // Reset mid-hold at 1134; synchronizers clear so stepping resumes two edges later.
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1136);
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1136);
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1136);
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1137);
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1138);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1139);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1140);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1140);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n = vecs[i].rst_n;
            a_k0    = vecs[i].k0;
            a_k1    = vecs[i].k1;
            a_k2    = vecs[i].k2;
            @(posedge clk);
            #1;
            check("table_a", i, a_div, vecs[i].exp);
            if (i == 1) check("reset_b", i, b_div, 32'd1136);
        end

        // Instance B: walk down to the floor at one step per 4 clocks.
        a_k0 = 1'b0; a_k1 = 1'b0; a_k2 = 1'b0;
        b_k0 = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (e == 3)  check("b_first_dec", e, b_div, 32'd1135);
            if (e == 7)  check("b_second_dec", e, b_div, 32'd1134);
            if (e == 30) check("b_floor", e, b_div, 32'd1130);
        end

        // Switch straight to increment mid-count: new direction steps at once, then every 4.
        b_exp = '{1130, 1130, 1131, 1131, 1131, 1131, 1132, 1132, 1132, 1132, 1133, 1133};
        b_k0 = 1'b0;
        b_k1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("b_repeat4", i, b_div, b_exp[i][31:0]);
        end
        check("a_idle_hold", 0, a_div, 32'd1140);

        b_k1 = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
